// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the key-expansion datapath.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_KEYS   = NUM_ROUNDS + 1;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } kg_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is unused; rounds are numbered 1..10.
  localparam logic [7:0] RCON [NUM_KEYS] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/key_expansion_round.sv
// One AES-128 key-schedule step: derives round key r from round key r-1.
module key_expansion_round
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, t_w;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
  assign t_w   = sub_w ^ {rcon, 24'h0};

  assign n0 = w0 ^ t_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_generator.sv
// AES-128 key expansion: captures a cipher key and fills an 11-entry round-key file, one round per clock.
module key_generator
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic [3:0]   read_addr,
  input  logic         WE_key_generation,
  input  logic [127:0] original_key,
  output logic [127:0] round_key_0,
  output logic [127:0] round_key_x,
  output logic         generation_done
);

  kg_state_e  state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       done_q, done_d;
  round_key_t keys_q [NUM_KEYS];
  round_key_t keys_d [NUM_KEYS];

  round_key_t prev_key, next_key;
  logic [7:0] rcon_sel;

  always_comb begin
    prev_key = '0;
    rcon_sel = 8'h00;
    for (int i = 1; i < NUM_KEYS; i++) begin
      if (rnd_q == 4'(i)) begin
        prev_key = keys_q[i-1];
        rcon_sel = RCON[i];
      end
    end
  end

  key_expansion_round u_round (
    .prev_key (prev_key),
    .rcon     (rcon_sel),
    .next_key (next_key)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    done_d  = done_q;
    for (int i = 0; i < NUM_KEYS; i++) keys_d[i] = keys_q[i];

    unique case (state_q)
      ST_IDLE: begin
        if (WE_key_generation) begin
          keys_d[0] = original_key;
          rnd_d     = 4'd1;
          done_d    = 1'b0;
          state_d   = ST_GEN;
        end
      end
      ST_GEN: begin
        for (int i = 1; i < NUM_KEYS; i++) begin
          if (rnd_q == 4'(i)) keys_d[i] = next_key;
        end
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NUM_ROUNDS)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Start is level-sensitive, so WE must drop before another run can begin.
        if (!WE_key_generation) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) keys_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_KEYS; i++) keys_q[i] <= keys_d[i];
    end
  end

  always_comb begin
    round_key_x = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (read_addr == 4'(i)) round_key_x = keys_q[i];
    end
  end

  assign round_key_0     = keys_q[0];
  assign generation_done = done_q;

endmodule

// File: tb/tb_key_generator.sv
// Directed and random checks of key_generator against a word-level FIPS-197 key schedule model.
module tb_key_generator;

  logic         clk;
  logic         n_rst;
  logic [3:0]   read_addr;
  logic         WE_key_generation;
  logic [127:0] original_key;
  logic [127:0] round_key_0;
  logic [127:0] round_key_x;
  logic         generation_done;

  int total = 0;
  int bad   = 0;

  logic [127:0] ref_k [11];
  logic [127:0] ref_a [11];
  logic [127:0] ref_b [11];

  key_generator dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .read_addr         (read_addr),
    .WE_key_generation (WE_key_generation),
    .original_key      (original_key),
    .round_key_0       (round_key_0),
    .round_key_x       (round_key_x),
    .generation_done   (generation_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) arithmetic: the S-box is derived from the field inverse plus the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  // Standard 44-word schedule, grouped four words per round key.
  task automatic build(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ref_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] a, input string tag, input logic [127:0] exp);
    read_addr = a;
    #1;
    chk(tag, round_key_x, exp);
  endtask

  task automatic run_gen(input logic [127:0] key);
    build(key);
    original_key      = key;
    WE_key_generation = 1'b1;
    tick();
    WE_key_generation = 1'b0;
    original_key      = {$urandom, $urandom, $urandom, $urandom};
    repeat (10) tick();
    chk("done_after_gen", 128'(generation_done), 128'd1);
  endtask

  initial begin
    logic [127:0] key;

    n_rst = 1'b0;
    read_addr = 4'd0;
    WE_key_generation = 1'b0;
    original_key = '0;
    #2;
    chk("rst_rk0", round_key_0, '0);
    chk("rst_rkx", round_key_x, '0);
    chk("rst_done", 128'(generation_done), '0);
    tick();
    n_rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      original_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("idle_rk0", round_key_0, '0);
      chk("idle_done", 128'(generation_done), '0);
    end

    // Single start with the test-plan key; stepped slot-by-slot as rounds land.
    key = 128'h7468697369737468656b657930303030;
    build(key);
    original_key = key;
    read_addr = 4'd1;
    WE_key_generation = 1'b1;
    tick();
    WE_key_generation = 1'b0;
    original_key = ~key;
    chk("e0_rk0", round_key_0, key);
    chk("e0_done", 128'(generation_done), '0);
    for (int r = 1; r <= 10; r++) begin
      tick();
      peek(4'(r), "step_slot", ref_k[r]);
      if (r == 1) chk("step_slot1_const", round_key_x, 128'h716c6d77181f191f7d747c664d444c56);
      chk("step_done", 128'(generation_done), (r == 10) ? 128'd1 : 128'd0);
    end
    tick();
    chk("done_held_idle", 128'(generation_done), 128'd1);

    // FIPS-197 appendix key, full address sweep including unmapped addresses.
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_gen(key);
    for (int a = 0; a < 16; a++) peek(4'(a), "sweep", (a < 11) ? ref_k[a] : 128'h0);
    peek(4'd1, "fips_addr1", 128'ha0fafe1788542cb123a339392a6c7605);
    peek(4'd10, "fips_addr10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_rk0", round_key_0, key);

    for (int k = 0; k < 3; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      run_gen(key);
      chk("rand_rk0", round_key_0, key);
      for (int j = 0; j < 4; j++) begin
        int a;
        a = $urandom_range(0, 15);
        peek(4'(a), "rand_slot", (a < 11) ? ref_k[a] : 128'h0);
      end
      tick();
    end

    // WE held high through GEN and DONE: exactly one run, then a clean restart.
    key = {$urandom, $urandom, $urandom, $urandom};
    build(key);
    for (int i = 0; i < 11; i++) ref_a[i] = ref_k[i];
    original_key = key;
    WE_key_generation = 1'b1;
    tick();
    repeat (10) tick();
    chk("held_done", 128'(generation_done), 128'd1);
    original_key = {$urandom, $urandom, $urandom, $urandom};
    repeat (5) tick();
    chk("held_no_restart_done", 128'(generation_done), 128'd1);
    chk("held_no_restart_rk0", round_key_0, key);
    peek(4'd10, "held_slot10", ref_a[10]);

    WE_key_generation = 1'b0;
    tick();
    key = {$urandom, $urandom, $urandom, $urandom};
    build(key);
    for (int i = 0; i < 11; i++) ref_b[i] = ref_k[i];
    original_key = key;
    WE_key_generation = 1'b1;
    tick();
    chk("restart_done_clear", 128'(generation_done), '0);
    chk("restart_rk0", round_key_0, key);
    repeat (3) tick();
    peek(4'd3, "restart_slot3", ref_b[3]);
    peek(4'd7, "restart_stale_slot7", ref_a[7]);
    repeat (7) tick();
    chk("restart_done", 128'(generation_done), 128'd1);
    peek(4'd10, "restart_slot10", ref_b[10]);
    WE_key_generation = 1'b0;
    tick();

    // Asynchronous reset partway through generation.
    original_key = {$urandom, $urandom, $urandom, $urandom};
    WE_key_generation = 1'b1;
    tick();
    WE_key_generation = 1'b0;
    repeat (5) tick();
    n_rst = 1'b0;
    #1;
    chk("midrst_rk0", round_key_0, '0);
    chk("midrst_done", 128'(generation_done), '0);
    for (int a = 0; a < 11; a++) peek(4'(a), "midrst_slot", 128'h0);
    tick();
    n_rst = 1'b1;
    repeat (12) tick();
    chk("postrst_done", 128'(generation_done), '0);
    chk("postrst_rk0", round_key_0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
